controlador_registrador7b: RTL and testbench
============================================

CONTROLADOR_REGISTRADOR7B -- requirements
Module: controlador_registrador7b

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized button cycles required; legal range is 2..15.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 botao  input  1  raw confirm push-button, active-high, asynchronous to clk.
REQ-005 ch1, ch0  input  1 each  target register select; index = {ch1,ch0}.
REQ-006 dado_in  input  7  value to write into the selected 7-bit register.
REQ-007 limpar  input  1  level request to clear all four registers.
REQ-008 sinal  output  4  one-hot per-register load strobe, registered.
REQ-009 d_out  output  7  data bus shared by all four registers, registered.
REQ-010 ocupado  output  1  high whenever the FSM is not in IDLE.
REQ-011 reg_valido  output  4  bit i is set once register i has been written since the last clear.
REQ-012 sobrescrita  output  1  one-cycle pulse, coincident with sinal, when the written register was already valid.
REQ-013 contador_escritas  output  4  count of completed loads since the last clear, saturating at 15.

Function
REQ-014 botao SHALL pass through a 2-flop synchronizer; botao_sync is the second-stage output, and no other logic uses raw botao.
REQ-015 The FSM SHALL have exactly five states: IDLE, DEBOUNCE, LOAD, WAIT_RELEASE, CLEAR.
REQ-016 IDLE transitions: limpar=1 -> CLEAR; else botao_sync=1 -> DEBOUNCE with the stability counter set to 1; else stay in IDLE.
REQ-017 In DEBOUNCE, botao_sync=0 SHALL return the FSM to IDLE and zero the counter.
REQ-018 In DEBOUNCE, when the counter reaches DEBOUNCE_CYCLES, the FSM SHALL capture {ch1,ch0} and dado_in on that edge and enter LOAD; otherwise the counter increments.
REQ-019 With botao held high from edge 0 and all inputs stable, LOAD SHALL be entered at edge DEBOUNCE_CYCLES+2; for the default of 4, sinal is high between edges 6 and 7.
REQ-020 LOAD SHALL last exactly one cycle, with these outputs:
- sinal = one-hot of the captured index;
- d_out = captured data;
- sobrescrita = previous reg_valido[index];
- reg_valido[index] set;
- contador_escritas incremented, saturating at 15.
REQ-021 LOAD SHALL go unconditionally to WAIT_RELEASE.
REQ-022 WAIT_RELEASE SHALL return to IDLE only after botao_sync has been 0 for DEBOUNCE_CYCLES consecutive cycles; any 1 restarts the count, so holding the button produces exactly one load.
REQ-023 CLEAR SHALL last 4 cycles, asserting sinal = 0001, 0010, 0100, 1000 in order with d_out = 0.
REQ-024 On CLEAR exit, reg_valido = 0 and contador_escritas = 0, and the FSM returns to IDLE.
REQ-025 limpar SHALL be ignored outside IDLE; if limpar is still high on return to IDLE, a new CLEAR starts.
REQ-026 If limpar and botao_sync are both high in IDLE, limpar wins and the button press is discarded.
REQ-027 ch1, ch0 and dado_in changes after capture SHALL NOT affect an in-progress LOAD.
REQ-028 Outside LOAD and CLEAR: sinal = 0000, sobrescrita = 0, and d_out holds its last value.
REQ-029 sinal SHALL never have more than one bit set in any cycle.
REQ-030 ocupado SHALL equal (state != IDLE), registered together with the state.

Reset
REQ-031 reset=1 at a rising edge SHALL force all of the following, overriding every other input including in-progress LOAD or CLEAR:
- state = IDLE;
- synchronizer flops and counters = 0;
- sinal = 0000, d_out = 0000000;
- ocupado = 0, reg_valido = 0000, sobrescrita = 0, contador_escritas = 0.
REQ-032 Reset asserted mid-CLEAR SHALL abort the sequence with no further strobes.
REQ-033 Reset asserted mid-LOAD SHALL suppress that cycle's strobe.

Verification
REQ-034 Single write: ch1,ch0 = 1,0, dado_in = 7'h55, botao high from edge 0 for 20 cycles -> sinal = 0100 and d_out = 55 exactly in the cycle after edge 6; reg_valido = 0100; contador_escritas = 1; no second strobe.
REQ-035 Glitch rejection: botao high for 3 cycles then low (DEBOUNCE_CYCLES = 4) -> no sinal pulse and state back in IDLE.
REQ-036 Overwrite: two separate presses to index 3, data 7'h01 then 7'h7F -> second strobe sinal = 1000, d_out = 7F, sobrescrita = 1; contador_escritas = 2.
REQ-037 Clear with priority: limpar and botao both asserted in IDLE -> four strobes 0001..1000 with d_out = 0 on consecutive cycles; then reg_valido = 0 and contador_escritas = 0; no write from the button.
REQ-038 Saturation: 17 complete presses -> contador_escritas = 15.
REQ-039 Reset mid-CLEAR: reset pulsed during the second CLEAR cycle -> no further sinal bits; all outputs zero on the next cycle.

Source files
------------

// File: rtl/controlador_registrador7b.sv
// -----------------------------------------------------------------------------
// controlador_registrador7b
// Load controller for a bank of four 7-bit registers that share one data bus.
// A debounced push-button press writes dado_in into the register selected by
// {ch1,ch0}. A limpar request walks a zero through all four registers.
//
// Ports
//   clk                in   system clock, rising edge
//   reset              in   synchronous, active-high
//   botao              in   raw confirm button (asynchronous to clk)
//   ch1, ch0           in   target register index = {ch1,ch0}
//   dado_in     [6:0]  in   data to write
//   limpar             in   level request to clear all four registers
//   sinal       [3:0]  out  one-hot load strobe (registered)
//   d_out       [6:0]  out  shared data bus (registered)
//   ocupado            out  FSM is not in IDLE
//   reg_valido  [3:0]  out  register i written since the last clear
//   sobrescrita        out  pulse with sinal when the target was already valid
//   contador_escritas [3:0] out  completed loads since last clear, saturating
// -----------------------------------------------------------------------------
module controlador_registrador7b #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botao,
    input  logic       ch1,
    input  logic       ch0,
    input  logic [6:0] dado_in,
    input  logic       limpar,
    output logic [3:0] sinal,
    output logic [6:0] d_out,
    output logic       ocupado,
    output logic [3:0] reg_valido,
    output logic       sobrescrita,
    output logic [3:0] contador_escritas
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        LOAD,
        WAIT_RELEASE,
        CLEAR
    } state_t;

    localparam logic [3:0] DC    = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] DC_M1 = 4'(DEBOUNCE_CYCLES - 1);

    state_t     state_q;
    logic       sync1_q;
    logic       sync2_q;
    logic [3:0] cnt_q;
    logic [3:0] sinal_q;
    logic [6:0] d_out_q;
    logic       ocupado_q;
    logic [3:0] reg_valido_q;
    logic       sobrescrita_q;
    logic [3:0] contador_q;

    logic [1:0] sel;
    assign sel = {ch1, ch0};

    // Outputs are registered on the transition edge, so the strobe for a
    // state appears during the cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cnt_q         <= '0;
            sinal_q       <= '0;
            d_out_q       <= '0;
            ocupado_q     <= 1'b0;
            reg_valido_q  <= '0;
            sobrescrita_q <= 1'b0;
            contador_q    <= '0;
        end else begin
            sync1_q       <= botao;
            sync2_q       <= sync1_q;
            sinal_q       <= '0;
            sobrescrita_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (limpar) begin
                        state_q   <= CLEAR;
                        ocupado_q <= 1'b1;
                        sinal_q   <= 4'b0001;
                        d_out_q   <= '0;
                        cnt_q     <= 4'd1;
                    end else if (sync2_q) begin
                        state_q   <= DEBOUNCE;
                        ocupado_q <= 1'b1;
                        cnt_q     <= 4'd1;
                    end
                end

                DEBOUNCE: begin
                    if (!sync2_q) begin
                        state_q   <= IDLE;
                        ocupado_q <= 1'b0;
                        cnt_q     <= '0;
                    end else if (cnt_q == DC) begin
                        // Capture select and data now; later input changes
                        // cannot disturb the LOAD cycle.
                        state_q            <= LOAD;
                        sinal_q            <= 4'b0001 << sel;
                        d_out_q            <= dado_in;
                        sobrescrita_q      <= reg_valido_q[sel];
                        reg_valido_q[sel]  <= 1'b1;
                        if (contador_q != 4'hF) begin
                            contador_q <= contador_q + 4'd1;
                        end
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                LOAD: begin
                    state_q <= WAIT_RELEASE;
                    cnt_q   <= '0;
                end

                WAIT_RELEASE: begin
                    // cnt_q counts consecutive released cycles already seen.
                    if (sync2_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DC_M1) begin
                        state_q   <= IDLE;
                        ocupado_q <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end

                CLEAR: begin
                    // cnt_q is the index of the next strobe; 4 means all done.
                    if (cnt_q == 4'd4) begin
                        state_q      <= IDLE;
                        ocupado_q    <= 1'b0;
                        reg_valido_q <= '0;
                        contador_q   <= '0;
                        cnt_q        <= '0;
                    end else begin
                        sinal_q <= 4'b0001 << cnt_q[1:0];
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    ocupado_q <= 1'b0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign sinal             = sinal_q;
    assign d_out             = d_out_q;
    assign ocupado           = ocupado_q;
    assign reg_valido        = reg_valido_q;
    assign sobrescrita       = sobrescrita_q;
    assign contador_escritas = contador_q;

endmodule

// File: tb/tb_controlador_registrador7b.sv
// -----------------------------------------------------------------------------
// Bench for controlador_registrador7b (DEBOUNCE_CYCLES = 4).
// Expected strobes are queued when a press or clear is driven; a negedge
// monitor pops and compares every non-zero sinal cycle.
// -----------------------------------------------------------------------------
module tb_controlador_registrador7b;

    logic       clk = 1'b0;
    logic       reset;
    logic       botao;
    logic       ch1;
    logic       ch0;
    logic [6:0] dado_in;
    logic       limpar;
    logic [3:0] sinal;
    logic [6:0] d_out;
    logic       ocupado;
    logic [3:0] reg_valido;
    logic       sobrescrita;
    logic [3:0] contador_escritas;

    controlador_registrador7b #(.DEBOUNCE_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .botao             (botao),
        .ch1               (ch1),
        .ch0               (ch0),
        .dado_in           (dado_in),
        .limpar            (limpar),
        .sinal             (sinal),
        .d_out             (d_out),
        .ocupado           (ocupado),
        .reg_valido        (reg_valido),
        .sobrescrita       (sobrescrita),
        .contador_escritas (contador_escritas)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] s;
        logic [6:0] d;
        logic       o;
    } strobe_t;

    strobe_t    sb[$];
    int         errors = 0;
    int         checks = 0;
    logic       mon_en = 1'b0;
    logic [3:0] m_valid;
    logic [3:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && sinal !== 4'b0000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_strobe observed sinal=%b expected none", sinal);
            end else begin
                strobe_t e;
                e = sb.pop_front();
                check("strobe_onehot", 32'($onehot(sinal)), 32'd1);
                check("strobe_sinal", 32'(sinal), 32'(e.s));
                check("strobe_d_out", 32'(d_out), 32'(e.d));
                check("strobe_sobrescrita", 32'(sobrescrita), 32'(e.o));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_valid = '0;
        m_cnt   = '0;
    endtask

    // Full press on index idx with data d: hold, then release long enough
    // for WAIT_RELEASE to return to IDLE. The model predicts the strobe.
    task automatic press(input logic [1:0] idx, input logic [6:0] d);
        strobe_t e;
        e.s = 4'b0001 << idx;
        e.d = d;
        e.o = m_valid[idx];
        sb.push_back(e);
        m_valid[idx] = 1'b1;
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        {ch1, ch0} = idx;
        dado_in    = d;
        botao      = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        // Inputs moving after capture must not create another load.
        {ch1, ch0} = ~idx;
        dado_in    = ~d;
        repeat (3) @(posedge clk);
        #1 botao = 1'b0;
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        botao   = 1'b0;
        ch1     = 1'b0;
        ch0     = 1'b0;
        dado_in = '0;
        limpar  = 1'b0;
        m_valid = '0;
        m_cnt   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sinal", 32'(sinal), 32'h0);
        check("rst_d_out", 32'(d_out), 32'h0);
        check("rst_ocupado", 32'(ocupado), 32'h0);
        check("rst_reg_valido", 32'(reg_valido), 32'h0);
        check("rst_sobrescrita", 32'(sobrescrita), 32'h0);
        check("rst_contador", 32'(contador_escritas), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Single write: strobe exactly in the cycle after edge 6
        @(posedge clk);
        #1;
        ch1 = 1'b1; ch0 = 1'b0; dado_in = 7'h55; botao = 1'b1;
        sb.push_back('{s: 4'b0100, d: 7'h55, o: 1'b0});
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 1) check("single_ocupado_idle", 32'(ocupado), 32'h0);
            if (e == 2) check("single_ocupado_busy", 32'(ocupado), 32'h1);
            if (e == 5) check("single_before_edge6", 32'(sinal), 32'h0);
            if (e == 6) check("single_at_edge6", 32'(sinal), 32'h4);
            if (e == 7) check("single_after_edge6", 32'(sinal), 32'h0);
            if (e == 7) check("single_d_out_hold", 32'(d_out), 32'h55);
        end
        #1 botao = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("single_reg_valido", 32'(reg_valido), 32'h4);
        check("single_contador", 32'(contador_escritas), 32'h1);
        check("single_idle", 32'(ocupado), 32'h0);

        // Glitch rejection: three high cycles only
        @(posedge clk);
        #1 botao = 1'b1;
        repeat (3) @(posedge clk);
        #1 botao = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("glitch_idle", 32'(ocupado), 32'h0);
        check("glitch_contador", 32'(contador_escritas), 32'h1);

        // Overwrite on index 3
        do_reset();
        press(2'd3, 7'h01);
        press(2'd3, 7'h7F);
        @(negedge clk);
        check("ovw_contador", 32'(contador_escritas), 32'h2);
        check("ovw_reg_valido", 32'(reg_valido), 32'h8);
        check("ovw_d_out", 32'(d_out), 32'h7F);

        // Clear with priority over a simultaneous button press
        press(2'd0, 7'h2A);
        @(posedge clk);
        #1 botao = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 limpar = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back('{s: 4'b0001 << i, d: 7'h00, o: 1'b0});
        @(posedge clk);
        #1 begin limpar = 1'b0; botao = 1'b0; end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("clr_seq", 32'(sinal), 32'(4'b0001 << i));
            @(posedge clk);
        end
        @(negedge clk);
        check("clr_done_sinal", 32'(sinal), 32'h0);
        check("clr_reg_valido", 32'(reg_valido), 32'h0);
        check("clr_contador", 32'(contador_escritas), 32'h0);
        m_valid = '0;
        m_cnt   = '0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("clr_no_write", 32'(contador_escritas), 32'h0);
        check("clr_idle", 32'(ocupado), 32'h0);

        // Saturation after 17 presses
        do_reset();
        for (int i = 0; i < 17; i++) press(2'(i), 7'(i * 5 + 3));
        @(negedge clk);
        check("sat_contador", 32'(contador_escritas), 32'hF);
        check("sat_reg_valido", 32'(reg_valido), 32'hF);

        // Reset during the second CLEAR cycle
        @(posedge clk);
        #1 limpar = 1'b1;
        sb.push_back('{s: 4'b0001, d: 7'h00, o: 1'b0});
        sb.push_back('{s: 4'b0010, d: 7'h00, o: 1'b0});
        @(posedge clk);
        #1 limpar = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstclr_sinal", 32'(sinal), 32'h0);
        check("rstclr_d_out", 32'(d_out), 32'h0);
        check("rstclr_ocupado", 32'(ocupado), 32'h0);
        check("rstclr_reg_valido", 32'(reg_valido), 32'h0);
        check("rstclr_contador", 32'(contador_escritas), 32'h0);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rstclr_idle", 32'(ocupado), 32'h0);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
